data_mem_responder: RTL and testbench

Wait-state data memory responder: the memory-side end of the CPU data port.
Replaces the always-ready data memory with word-organised storage that drives real data_read_rdy / data_write_ack handshakes after programmable latencies.
Sits between riscv_rv32i data port and nothing else. Internal storage; flags out-of-range accesses.

---
 rtl/data_mem_responder.sv | 131 +++++++++++++
 tb/tb_data_mem_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering the CPU data port with real rdy/ack handshakes.
// Latency: rdy exactly READ_LATENCY cycles, ack exactly WRITE_LATENCY cycles after the request is first seen in IDLE.
// Backpressure: one access at a time; the initiator holds its enable until the completion pulse, writes win ties.
module data_mem_responder #(
    parameter int DEPTH_WORDS   = 1024,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_address,
    input  logic        data_read_enable,
    output logic [31:0] data_read_data,
    output logic        data_read_rdy,
    input  logic        data_write_enable,
    input  logic [3:0]  data_write_byte_enable,
    input  logic [31:0] data_write_data,
    output logic        data_write_ack,
    output logic        access_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, RESP_RD, RESP_WR} state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [29:0] widx_q, widx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdy_q, rdy_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        in_range;
    logic        wr_commit;

    logic [31:0] mem [DEPTH_WORDS];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            IDLE: begin
                if (data_write_enable) begin
                    widx_d  = data_address[31:2];
                    wdata_d = data_write_data;
                    be_d    = data_write_byte_enable;
                    if (WRITE_LATENCY == 1) begin
                        state_d = RESP_WR;
                    end else begin
                        state_d = WR_WAIT;
                        count_d = 4'(WRITE_LATENCY - 1);
                    end
                end else if (data_read_enable) begin
                    widx_d = data_address[31:2];
                    if (READ_LATENCY == 1) begin
                        state_d = RESP_RD;
                    end else begin
                        state_d = RD_WAIT;
                        count_d = 4'(READ_LATENCY - 1);
                    end
                end
            end
            RD_WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) state_d = RESP_RD;
            end
            WR_WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) state_d = RESP_WR;
            end
            default: state_d = IDLE;
        endcase

        // RESP states always fall back to IDLE, so state_d==RESP_* marks the entering edge
        in_range  = widx_d < 30'(DEPTH_WORDS);
        rdy_d     = (state_d == RESP_RD);
        ack_d     = (state_d == RESP_WR);
        err_d     = (rdy_d | ack_d) & ~in_range;
        busy_d    = (state_d != IDLE);
        wr_commit = ack_d & in_range;
        rdata_d   = rdata_q;
        if (rdy_d) rdata_d = in_range ? mem[widx_d[AW-1:0]] : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            widx_q  <= 30'd0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            rdy_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Storage is never reset; rst gating keeps an aborted write from landing
    always_ff @(posedge clk) begin
        if (wr_commit && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (be_d[i]) mem[widx_d[AW-1:0]][8*i +: 8] <= wdata_d[8*i +: 8];
            end
        end
    end

    assign data_read_data = rdata_q;
    assign data_read_rdy  = rdy_q;
    assign data_write_ack = ack_q;
    assign access_err     = err_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: two instances (RL=3/WL=1 and RL=2/WL=4) share stimulus, sel picks one.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        re, we, sel;

    logic [31:0] a_rdata, b_rdata, rdata;
    logic        a_rdy, b_rdy, rdy, a_ack, b_ack, ack, a_err, b_err, acc_err, a_busy, b_busy, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(3), .WRITE_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .data_address(addr),
        .data_read_enable(re & ~sel), .data_read_data(a_rdata), .data_read_rdy(a_rdy),
        .data_write_enable(we & ~sel), .data_write_byte_enable(be), .data_write_data(wdata),
        .data_write_ack(a_ack), .access_err(a_err), .busy(a_busy)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(2), .WRITE_LATENCY(4)) dut_b (
        .clk(clk), .rst(rst), .data_address(addr),
        .data_read_enable(re & sel), .data_read_data(b_rdata), .data_read_rdy(b_rdy),
        .data_write_enable(we & sel), .data_write_byte_enable(be), .data_write_data(wdata),
        .data_write_ack(b_ack), .access_err(b_err), .busy(b_busy)
    );

    assign rdata   = sel ? b_rdata : a_rdata;
    assign rdy     = sel ? b_rdy   : a_rdy;
    assign ack     = sel ? b_ack   : a_ack;
    assign acc_err = sel ? b_err   : a_err;
    assign busy    = sel ? b_busy  : a_busy;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus helpers: called in an IDLE cycle, return in the next IDLE cycle; cyc=-1 on timeout
    task automatic do_write(input logic [31:0] ad, input logic [31:0] d, input logic [3:0] b,
                            output int cyc, output logic err);
        addr = ad; wdata = d; be = b; we = 1'b1; cyc = -1; err = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (ack) begin cyc = n; err = acc_err; break; end
        end
        we = 1'b0;
        step();
    endtask

    task automatic do_read(input logic [31:0] ad, output logic [31:0] d, output int cyc, output logic err);
        addr = ad; re = 1'b1; cyc = -1; err = 1'b0; d = 32'hx;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (rdy) begin cyc = n; err = acc_err; d = rdata; break; end
        end
        re = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; re = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0; sel = 1'b0;
        step(); step();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if ({rdy, ack, acc_err, busy} !== 4'b0000) begin
                failures++; $display("FAIL reset_flags sel=%0d got=%b exp=0000", s, {rdy, ack, acc_err, busy});
            end
            checks++;
            if (rdata !== 32'h0) begin
                failures++; $display("FAIL reset_rdata sel=%0d got=%h exp=00000000", s, rdata);
            end
        end
        sel = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_latency();
        int cyc; logic err;
        sel = 1'b0;
        do_write(32'h10, 32'hDEADBEEF, 4'hF, cyc, err);
        checks++;
        if (cyc !== 1 || err !== 1'b0) begin
            failures++; $display("FAIL lat_write_ack got cyc=%0d err=%b exp cyc=1 err=0", cyc, err);
        end
        addr = 32'h10; re = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            step();
            checks++;
            if (rdy !== (n == 3) || busy !== 1'b1) begin
                failures++; $display("FAIL lat_read_rdy cycle=%0d got rdy=%b busy=%b exp rdy=%b busy=1", n, rdy, busy, n == 3);
            end
        end
        checks++;
        if (rdata !== 32'hDEADBEEF || acc_err !== 1'b0) begin
            failures++; $display("FAIL lat_read_data got=%h err=%b exp=deadbeef err=0", rdata, acc_err);
        end
        re = 1'b0;
        step();
        checks++;
        if (rdy !== 1'b0 || busy !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL lat_hold got rdy=%b busy=%b data=%h exp rdy=0 busy=0 data=deadbeef", rdy, busy, rdata);
        end
    endtask

    task automatic test_byte_lanes();
        int cyc; logic err; logic [31:0] d;
        sel = 1'b0;
        do_write(32'h20, 32'h11223344, 4'hF, cyc, err);
        do_write(32'h20, 32'hAABBCCDD, 4'b0101, cyc, err);
        do_read(32'h20, d, cyc, err);
        checks++;
        if (d !== 32'h11BB33DD || cyc !== 3) begin
            failures++; $display("FAIL lanes_0101 got=%h cyc=%0d exp=11bb33dd cyc=3", d, cyc);
        end
        do_write(32'h20, 32'hFFFFFFFF, 4'b0000, cyc, err);
        checks++;
        if (cyc !== 1 || err !== 1'b0) begin
            failures++; $display("FAIL lanes_0000_ack got cyc=%0d err=%b exp cyc=1 err=0", cyc, err);
        end
        do_read(32'h20, d, cyc, err);
        checks++;
        if (d !== 32'h11BB33DD) begin
            failures++; $display("FAIL lanes_0000_unchanged got=%h exp=11bb33dd", d);
        end
    endtask

    task automatic test_simultaneous();
        int ack_at = -1, rdy_at = -1; logic [31:0] got = 32'hx;
        sel = 1'b0;
        addr = 32'h30; wdata = 32'h5A5A5A5A; be = 4'hF; we = 1'b1; re = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (ack && ack_at < 0) ack_at = n;
            if (rdy && rdy_at < 0) begin rdy_at = n; got = rdata; end
            if (ack) we = 1'b0;
            if (rdy) re = 1'b0;
        end
        checks++;
        if (ack_at !== 1 || rdy_at !== 5) begin
            failures++; $display("FAIL simul_order got ack_at=%0d rdy_at=%0d exp ack_at=1 rdy_at=5", ack_at, rdy_at);
        end
        checks++;
        if (got !== 32'h5A5A5A5A) begin
            failures++; $display("FAIL simul_data got=%h exp=5a5a5a5a", got);
        end
        we = 1'b0; re = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc; logic err; int k = 0;
        logic [31:0] exp_d [4] = '{32'hA5000000, 32'hA5000001, 32'hA5000002, 32'hA5000003};
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_write(32'h40 + 32'(4 * i), exp_d[i], 4'hF, cyc, err);
            if (i == 0) begin
                checks++;
                if (cyc !== 4) begin
                    failures++; $display("FAIL b2b_write_latency got cyc=%0d exp=4", cyc);
                end
            end
        end
        addr = 32'h40; re = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            step();
            checks++;
            if (rdy !== ((n % 3) == 2)) begin
                failures++; $display("FAIL b2b_rdy cycle=%0d got=%b exp=%b", n, rdy, (n % 3) == 2);
            end
            if (rdy && k < 4) begin
                checks++;
                if (rdata !== exp_d[k]) begin
                    failures++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", k, rdata, exp_d[k]);
                end
                k++;
                addr = 32'h40 + 32'(4 * k);
                if (k == 4) re = 1'b0;
            end
        end
        re = 1'b0;
        step();
        checks++;
        if (k !== 4) begin
            failures++; $display("FAIL b2b_count got=%0d exp=4", k);
        end
    endtask

    task automatic test_out_of_range();
        int cyc; logic err; logic [31:0] d;
        sel = 1'b0;
        do_write(32'h0, 32'h0BADF00D, 4'hF, cyc, err);
        do_read(32'h1000, d, cyc, err);
        checks++;
        if (cyc !== 3 || err !== 1'b1 || d !== 32'h0) begin
            failures++; $display("FAIL oor_read got cyc=%0d err=%b data=%h exp cyc=3 err=1 data=0", cyc, err, d);
        end
        do_write(32'h1000, 32'hFFFFFFFF, 4'hF, cyc, err);
        checks++;
        if (cyc !== 1 || err !== 1'b1) begin
            failures++; $display("FAIL oor_write got cyc=%0d err=%b exp cyc=1 err=1", cyc, err);
        end
        do_read(32'h0, d, cyc, err);
        checks++;
        if (d !== 32'h0BADF00D || err !== 1'b0) begin
            failures++; $display("FAIL oor_no_alias got=%h err=%b exp=0badf00d err=0", d, err);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; logic err; logic [31:0] d; int acks = 0;
        sel = 1'b1;
        do_write(32'h50, 32'hCAFEF00D, 4'hF, cyc, err);
        addr = 32'h50; wdata = 32'h12345678; be = 4'hF; we = 1'b1;
        step(); step();
        checks++;
        if (busy !== 1'b1 || ack !== 1'b0) begin
            failures++; $display("FAIL rstmid_wait got busy=%b ack=%b exp busy=1 ack=0", busy, ack);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rdy, ack, acc_err, busy} !== 4'b0000 || rdata !== 32'h0) begin
            failures++; $display("FAIL rstmid_outputs got flags=%b data=%h exp flags=0000 data=0", {rdy, ack, acc_err, busy}, rdata);
        end
        we = 1'b0;
        step(); step();
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            step();
            if (ack) acks++;
        end
        checks++;
        if (acks !== 0) begin
            failures++; $display("FAIL rstmid_no_ack got=%0d exp=0", acks);
        end
        do_read(32'h50, d, cyc, err);
        checks++;
        if (d !== 32'hCAFEF00D || cyc !== 2) begin
            failures++; $display("FAIL rstmid_storage got=%h cyc=%0d exp=cafef00d cyc=2", d, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_byte_lanes();
        test_simultaneous();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
